// File: rtl/cat_update_scheduler.sv
// rtl/cat_update_scheduler.sv - CCT deadband filter and frame-aligned XYZ white point commit scheduler
module cat_update_scheduler #(
    parameter int unsigned HYST_K  = 50,
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] INIT_X  = 32'h0000F352,
    parameter logic [31:0] INIT_Y  = 32'h00010000,
    parameter logic [31:0] INIT_Z  = 32'h000116C9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] als_cct,
    input  logic        als_valid,
    input  logic        frame_start,
    output logic [15:0] conv_cct,
    output logic        conv_cct_valid,
    input  logic [95:0] conv_xyz,
    input  logic        conv_xyz_valid,
    output logic [95:0] xyz_active,
    output logic        xyz_update,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        PEND  = 2'd3
    } state_t;

    localparam int          TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);
    localparam logic [16:0] HYST     = 17'(HYST_K);
    localparam logic [95:0] INIT_XYZ = {INIT_Z, INIT_Y, INIT_X};

    state_t        state;
    logic [15:0]   last_cct;
    logic          first_flag;
    logic [15:0]   hold_cct;
    logic          hold_valid;
    logic [TW-1:0] timer;
    logic [15:0]   req_cct;
    logic [95:0]   pending;

    logic          sample_vld;
    logic [15:0]   sample;
    logic [16:0]   sample_ext;
    logic [16:0]   last_ext;
    logic [16:0]   diff;
    logic          accept;

    // Pick this cycle's candidate sample: a live strobe beats the held one
    always_comb begin
        sample_vld = 1'b0;
        sample     = als_cct;
        if (als_valid) begin
            sample_vld = 1'b1;
            sample     = als_cct;
        end else if (hold_valid) begin
            sample_vld = 1'b1;
            sample     = hold_cct;
        end
    end

    // Kelvin deadband against the last committed CCT, computed without wrap
    always_comb begin
        sample_ext = {1'b0, sample};
        last_ext   = {1'b0, last_cct};
        diff       = (sample_ext >= last_ext) ? (sample_ext - last_ext) : (last_ext - sample_ext);
        accept     = sample_vld && (first_flag || (diff >= HYST));
    end

    // Request/response sequencer with frame-aligned commit and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            conv_cct       <= 16'd0;
            conv_cct_valid <= 1'b0;
            xyz_active     <= INIT_XYZ;
            xyz_update     <= 1'b0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
            last_cct       <= 16'd0;
            first_flag     <= 1'b1;
            hold_cct       <= 16'd0;
            hold_valid     <= 1'b0;
            timer          <= '0;
            req_cct        <= 16'd0;
            pending        <= '0;
        end else begin
            conv_cct_valid <= 1'b0;
            xyz_update     <= 1'b0;

            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            // Samples arriving mid-conversion park in a one-deep, newest-wins holder
            if (als_valid && (state != IDLE)) begin
                hold_cct   <= als_cct;
                hold_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!als_valid && hold_valid) begin
                        hold_valid <= 1'b0;
                    end
                    if (accept) begin
                        conv_cct <= sample;
                        req_cct  <= sample;
                        state    <= ISSUE;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    conv_cct_valid <= 1'b1;
                    timer          <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    if (conv_xyz_valid) begin
                        pending <= conv_xyz;
                        state   <= PEND;
                    end else if (timer == TMAX) begin
                        // Give up on this request; last_cct stays so the next sample is judged fairly
                        if (!err_clr) begin
                            timeout_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                PEND: begin
                    if (frame_start) begin
                        xyz_active <= pending;
                        xyz_update <= 1'b1;
                        last_cct   <= req_cct;
                        first_flag <= 1'b0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cat_update_scheduler.sv
// tb/tb_cat_update_scheduler.sv - self-checking bench for cat_update_scheduler
module tb_cat_update_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] als_cct;
    logic        als_valid;
    logic        frame_start;
    logic [15:0] conv_cct;
    logic        conv_cct_valid;
    logic [95:0] conv_xyz;
    logic        conv_xyz_valid;
    logic [95:0] xyz_active;
    logic        xyz_update;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    localparam logic [95:0] INIT_XYZ = 96'h000116C9_00010000_0000F352;

    int checks = 0;
    int errors = 0;

    logic [15:0] req_q[$];
    logic [95:0] com_q[$];

    typedef struct {
        logic [15:0] cct;
        bit          issue;
    } vec_t;

    vec_t        vecs[10];
    logic [15:0] last_req;

    always #5 clk = ~clk;

    cat_update_scheduler #(
        .HYST_K (50),
        .TIMEOUT(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .als_cct       (als_cct),
        .als_valid     (als_valid),
        .frame_start   (frame_start),
        .conv_cct      (conv_cct),
        .conv_cct_valid(conv_cct_valid),
        .conv_xyz      (conv_xyz),
        .conv_xyz_valid(conv_xyz_valid),
        .xyz_active    (xyz_active),
        .xyz_update    (xyz_update),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    // Converter result model: D65 for 6500 K, otherwise a CCT-tagged pattern
    function automatic logic [95:0] xyz_of(input logic [15:0] c);
        if (c == 16'd6500) return INIT_XYZ;
        return {16'h0002, c, 32'h00010000, 16'h0001, c ^ 16'hA5A5};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge and matched against the scoreboard
    task automatic tick();
        logic [95:0] e;
        @(posedge clk);
        #1;
        if (conv_cct_valid === 1'b1) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_req_unexpected: got conv_cct %0d expected no request", conv_cct);
            end else begin
                e = {80'd0, req_q.pop_front()};
                check("sb_req_cct", {80'd0, conv_cct}, e);
            end
        end
        if (xyz_update === 1'b1) begin
            if (com_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_commit_unexpected: got xyz_active %h expected no update", xyz_active);
            end else begin
                e = com_q.pop_front();
                check("sb_commit_xyz", xyz_active, e);
            end
        end
    endtask

    task automatic issue_als(input logic [15:0] c);
        als_cct   = c;
        als_valid = 1'b1;
        tick();
        als_valid = 1'b0;
    endtask

    task automatic respond(input logic [15:0] c);
        conv_xyz       = xyz_of(c);
        conv_xyz_valid = 1'b1;
        tick();
        conv_xyz_valid = 1'b0;
    endtask

    task automatic commit(input logic [15:0] c);
        com_q.push_back(xyz_of(c));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("commit_pulse", {95'd0, xyz_update}, 96'd1);
        check("commit_value", xyz_active, xyz_of(c));
        tick();
        check("commit_pulse_end", {95'd0, xyz_update}, 96'd0);
    endtask

    // Called with the request strobe just visible: answer 4 cycles later, then commit
    task automatic full_convert(input logic [15:0] c);
        repeat (3) tick();
        respond(c);
        tick();
        check("pend_busy", {95'd0, busy}, 96'd1);
        check("pend_no_commit", xyz_active, xyz_active === xyz_of(c) && c != 16'd6500 ? ~xyz_of(c) : xyz_active);
        commit(c);
        last_req = c;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (conv_cct_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(name, {95'd0, conv_cct_valid}, 96'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'd6500,  1'b1};
        vecs[1] = '{16'd6530,  1'b0};
        vecs[2] = '{16'd6550,  1'b1};
        vecs[3] = '{16'd6501,  1'b0};
        vecs[4] = '{16'd6500,  1'b1};
        vecs[5] = '{16'd2000,  1'b1};
        vecs[6] = '{16'd65535, 1'b1};
        vecs[7] = '{16'd0,     1'b1};
        vecs[8] = '{16'd49,    1'b0};
        vecs[9] = '{16'd50,    1'b1};

        rst_n          = 1'b0;
        als_cct        = 16'd0;
        als_valid      = 1'b0;
        frame_start    = 1'b0;
        conv_xyz       = '0;
        conv_xyz_valid = 1'b0;
        err_clr        = 1'b0;
        last_req       = 16'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tick();

        check("reset_xyz_active", xyz_active, INIT_XYZ);
        check("reset_busy", {95'd0, busy}, 96'd0);
        check("reset_xyz_update", {95'd0, xyz_update}, 96'd0);
        check("reset_conv_cct", {80'd0, conv_cct}, 96'd0);
        check("reset_timeout_err", {95'd0, timeout_err}, 96'd0);

        // Deadband vectors, each followed by a full convert/commit when accepted
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].issue) req_q.push_back(vecs[i].cct);
            issue_als(vecs[i].cct);
            tick();
            if (vecs[i].issue) begin
                check("vec_req_valid", {95'd0, conv_cct_valid}, 96'd1);
                check("vec_req_cct", {80'd0, conv_cct}, {80'd0, vecs[i].cct});
                full_convert(vecs[i].cct);
                check("vec_idle_after_commit", {95'd0, busy}, 96'd0);
            end else begin
                tick();
                tick();
                check("vec_discard_idle", {95'd0, busy}, 96'd0);
                check("vec_conv_cct_held", {80'd0, conv_cct}, {80'd0, last_req});
            end
        end

        // Hold register: 4000 then 7000 while waiting; only 7000 is issued afterwards
        req_q.push_back(16'd6000);
        req_q.push_back(16'd7000);
        issue_als(16'd6000);
        tick();
        check("hold_first_req", {95'd0, conv_cct_valid}, 96'd1);
        als_cct   = 16'd4000;
        als_valid = 1'b1;
        tick();
        als_cct = 16'd7000;
        tick();
        als_valid = 1'b0;
        tick();
        respond(16'd6000);
        tick();
        commit(16'd6000);
        wait_req("hold_req_valid");
        check("hold_req_cct", {80'd0, conv_cct}, 96'd7000);
        full_convert(16'd7000);
        repeat (3) tick();
        check("hold_consumed_idle", {95'd0, busy}, 96'd0);

        // Converter silent: timeout exactly 16 cycles after ISSUE
        req_q.push_back(16'd8000);
        issue_als(16'd8000);
        tick();
        check("tmo_req", {95'd0, conv_cct_valid}, 96'd1);
        repeat (15) tick();
        check("tmo_not_yet", {95'd0, timeout_err}, 96'd0);
        check("tmo_still_busy", {95'd0, busy}, 96'd1);
        tick();
        check("tmo_set", {95'd0, timeout_err}, 96'd1);
        check("tmo_idle", {95'd0, busy}, 96'd0);
        check("tmo_xyz_kept", xyz_active, xyz_of(16'd7000));
        issue_als(16'd7030);
        tick();
        tick();
        check("tmo_last_cct_kept", {95'd0, busy}, 96'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", {95'd0, timeout_err}, 96'd0);

        // err_clr coincident with the timeout edge wins
        req_q.push_back(16'd9000);
        issue_als(16'd9000);
        tick();
        check("prio_req", {95'd0, conv_cct_valid}, 96'd1);
        repeat (15) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("prio_err_clr", {95'd0, timeout_err}, 96'd0);
        check("prio_idle", {95'd0, busy}, 96'd0);

        // Result and frame_start in the same cycle: commit waits for the next frame
        req_q.push_back(16'd8000);
        issue_als(16'd8000);
        tick();
        check("coinc_req", {95'd0, conv_cct_valid}, 96'd1);
        repeat (3) tick();
        conv_xyz       = xyz_of(16'd8000);
        conv_xyz_valid = 1'b1;
        frame_start    = 1'b1;
        tick();
        conv_xyz_valid = 1'b0;
        frame_start    = 1'b0;
        check("coinc_no_update", {95'd0, xyz_update}, 96'd0);
        check("coinc_pend", {95'd0, busy}, 96'd1);
        tick();
        tick();
        check("coinc_xyz_kept", xyz_active, xyz_of(16'd7000));
        commit(16'd8000);

        // Reset while holding a result in PEND discards it
        req_q.push_back(16'd9000);
        issue_als(16'd9000);
        tick();
        repeat (3) tick();
        respond(16'd9000);
        tick();
        check("rst_pend_busy", {95'd0, busy}, 96'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_xyz", xyz_active, INIT_XYZ);
        check("rst_async_busy", {95'd0, busy}, 96'd0);
        check("rst_async_conv_cct", {80'd0, conv_cct}, 96'd0);
        req_q.delete();
        com_q.delete();
        tick();
        rst_n = 1'b1;
        frame_start    = 1'b1;
        conv_xyz       = xyz_of(16'd1234);
        conv_xyz_valid = 1'b1;
        tick();
        frame_start    = 1'b0;
        conv_xyz_valid = 1'b0;
        tick();
        check("rst_no_commit", xyz_active, INIT_XYZ);
        check("rst_idle", {95'd0, busy}, 96'd0);

        // first_flag restored: a tiny CCT is accepted without deadband
        req_q.push_back(16'd10);
        issue_als(16'd10);
        tick();
        check("first_after_rst", {95'd0, conv_cct_valid}, 96'd1);
        full_convert(16'd10);

        repeat (4) tick();
        check("sb_drain", 96'(req_q.size() + com_q.size()), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cat_update_scheduler.md
Name: cat_update_scheduler

Overview:
Sequences the CCT-to-XYZ conversion datapath for the chromatic adaptation pipeline. Filters ambient-light-sensor CCT samples with a Kelvin hysteresis deadband and issues conversion requests to the converter one at a time. Captures the returned XYZ white point and commits it to the downstream adaptation-matrix stage only on a frame boundary, so the displayed frame never tears mid-frame.

Parameters:
HYST_K, 50, minimum |new CCT − last committed CCT| in Kelvin that triggers a new conversion.
TIMEOUT, 16, max cycles spent in WAIT for converter response; must be > 4.
INIT_X, 32'h0000F352, reset value of active X (D65, Q16.16).
INIT_Y, 32'h00010000, reset value of active Y (1.0, Q16.16).
INIT_Z, 32'h000116C9, reset value of active Z (D65, Q16.16).

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
als_cct  in  16  sensor CCT in Kelvin
als_valid  in  1  single-cycle strobe, als_cct valid
frame_start  in  1  single-cycle pulse at start of each video frame
conv_cct  out  16  CCT request to converter
conv_cct_valid  out  1  single-cycle request strobe to converter
conv_xyz  in  96  converter result {Z,Y,X}, each 32-bit Q16.16
conv_xyz_valid  in  1  single-cycle converter result strobe
xyz_active  out  96  committed white point {Z,Y,X} to adaptation stage
xyz_update  out  1  single-cycle pulse, xyz_active changed this cycle
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky converter-timeout flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset: state IDLE; conv_cct=0, conv_cct_valid=0, xyz_active={INIT_Z,INIT_Y,INIT_X}, xyz_update=0, busy=0, timeout_err=0; last_cct=0, first_flag=1, hold_valid=0, timer=0.
- All outputs registered. Reset mid-operation aborts any pending request/result; xyz_active returns to INIT values.
- Sample source per cycle in IDLE: als_valid if asserted, else the hold register if hold_valid (hold_valid cleared when consumed).
- als_valid while busy: als_cct written to hold register, hold_valid=1 (newest sample overwrites older).
- Deadband: diff = |sample − last_cct| in 17-bit unsigned arithmetic, no wrap. Accept if first_flag=1 or diff >= HYST_K; otherwise discard the sample and stay in IDLE.
- States:
  - IDLE: accepted sample → conv_cct<=sample, req_cct<=sample, go ISSUE.
  - ISSUE: conv_cct_valid=1 for exactly this cycle; timer<=0; go WAIT.
  - WAIT: timer increments each cycle. conv_xyz_valid → pending<=conv_xyz, go PEND. If timer reaches TIMEOUT−1 with no valid → timeout_err<=1, go IDLE; last_cct unchanged.
  - PEND: frame_start → xyz_active<=pending, xyz_update=1 on the same edge, last_cct<=req_cct, first_flag<=0, go IDLE.
- Latency: als_valid at cycle N → conv_cct_valid high at N+2 (IDLE registers, ISSUE drives). Converter nominal response is 4 cycles after its request.
- frame_start outside PEND is ignored, including frame_start coincident with conv_xyz_valid in WAIT; the commit waits for the next frame.
- conv_xyz_valid outside WAIT is ignored.
- err_clr has priority over a same-cycle timeout set.
- conv_cct holds its last request value between requests.

Test Plan:
- Reset, no stimulus → xyz_active=96'h000116C9_00010000_0000F352, busy=0, xyz_update=0.
- First als_cct=6500 at cycle N, converter returns X=0x0000F352 4 cycles later, frame_start afterwards → conv_cct=6500 with conv_cct_valid at N+2; xyz_active updated with a one-cycle xyz_update on the frame_start edge.
- After committing 6500: als_cct=6530 → no request issued; als_cct=6550 → request conv_cct=6550.
- While in WAIT: als_valid 4000 then 7000 → after commit, 7000 is taken from the hold register and issued; 4000 is never issued.
- Converter never responds, TIMEOUT=16 → timeout_err=1 and state IDLE 16 cycles after ISSUE; xyz_active unchanged; err_clr → timeout_err=0.
- conv_xyz_valid and frame_start in the same cycle → no update; xyz_update asserts on the next frame_start. Assert rst_n low in PEND → pending is discarded and xyz_active=INIT values.
